axis_pkt_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the single queue ingress (8-bit AXI-stream with tuser_mty and tlast) between NUM_SRC upstream packet sources.
- Locks the grant from the first accepted beat through the tlast beat, so packets are never interleaved in the queue.
- Drives the queue's drop_incmpt_pkt input when the watchdog option is built in.

---
 rtl/axis_pkt_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_axis_pkt_rr_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-stream queue ingress; optional watchdog via AXIS_ARB_WDOG_EN.
// Latency: one idle arbitration cycle per packet, then zero-latency combinational steering of the granted source.
// Backpressure: m_axis_tready passes straight to the granted source's tready; the grant never moves while stalled.
module axis_pkt_rr_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MTY_WIDTH   = 8,
    parameter int WDOG_CYCLES = 64,
    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_SRC-1:0]              s_axis_tvalid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]              s_axis_tlast,
    input  logic [NUM_SRC*MTY_WIDTH-1:0]    s_axis_tuser_mty,
    output logic [NUM_SRC-1:0]              s_axis_tready,
    output logic                            m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic [MTY_WIDTH-1:0]            m_axis_tuser_mty,
    input  logic                            m_axis_tready,
    output logic                            drop_incmpt_pkt,
    output logic [GW-1:0]                   grant_id,
    output logic                            busy
);

    typedef enum logic {IDLE, PASS} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] last_grant, last_nxt, grant_nxt, pick;
    logic          pick_vld;
    logic          beat, eop, expire;

    // Rotating priority: search starts one past the previous winner.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!pick_vld && s_axis_tvalid[(int'(last_grant) + k) % NUM_SRC]) begin
                pick     = GW'((int'(last_grant) + k) % NUM_SRC);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        m_axis_tvalid    = 1'b0;
        m_axis_tdata     = '0;
        m_axis_tlast     = 1'b0;
        m_axis_tuser_mty = '0;
        s_axis_tready    = '0;
        if (state == PASS) begin
            m_axis_tvalid           = s_axis_tvalid[grant_id];
            s_axis_tready[grant_id] = m_axis_tready;
            if (s_axis_tvalid[grant_id]) begin
                m_axis_tdata     = s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tlast     = s_axis_tlast[grant_id];
                m_axis_tuser_mty = s_axis_tuser_mty[grant_id*MTY_WIDTH +: MTY_WIDTH];
            end
        end
    end

    assign beat = m_axis_tvalid & m_axis_tready;
    assign eop  = beat & m_axis_tlast;
    assign busy = (state == PASS);

`ifdef AXIS_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] wdog_cnt, wdog_nxt;
    logic          starve, drop_q;

    // Only cycles where the granted source itself has nothing to offer count as starvation.
    assign starve = (state == PASS) && !s_axis_tvalid[grant_id];
    assign expire = starve && (wdog_cnt == CW'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_nxt = '0;
        if (state == PASS && !beat && !expire)
            wdog_nxt = starve ? wdog_cnt + 1'b1 : wdog_cnt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wdog_cnt <= '0;
            drop_q   <= 1'b0;
        end else begin
            wdog_cnt <= wdog_nxt;
            drop_q   <= expire;
        end
    end

    assign drop_incmpt_pkt = drop_q;
`else
    assign expire          = 1'b0;
    assign drop_incmpt_pkt = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt = pick;
                    state_nxt = PASS;
                end
            end
            PASS: begin
                if (eop || expire) begin
                    state_nxt = IDLE;
                    last_nxt  = grant_id;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_SRC - 1);
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
        end
    end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter with hand-computed expectations; watchdog steps follow AXIS_ARB_WDOG_EN.
module tb_axis_pkt_rr_arbiter;
    localparam int N = 4;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b1;
    logic [N-1:0] v, l;
    logic [7:0]   d [N];
    logic [7:0]   m [N];
    logic [N*8-1:0] tdata, tmty;
    logic [N-1:0] s_rdy;
    logic         m_vld, m_last, m_rdy, drop, busy;
    logic [7:0]   m_dat, m_mty;
    logic [1:0]   gid;
    int           n_chk = 0;
    int           n_fail = 0;
    int           c [N];

    always #5 aclk = ~aclk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign tdata[gi*8 +: 8] = d[gi];
        assign tmty[gi*8 +: 8]  = m[gi];
    end

    axis_pkt_rr_arbiter #(.NUM_SRC(N), .DATA_WIDTH(8), .MTY_WIDTH(8), .WDOG_CYCLES(64)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(v), .s_axis_tdata(tdata), .s_axis_tlast(l), .s_axis_tuser_mty(tmty),
        .s_axis_tready(s_rdy),
        .m_axis_tvalid(m_vld), .m_axis_tdata(m_dat), .m_axis_tlast(m_last), .m_axis_tuser_mty(m_mty),
        .m_axis_tready(m_rdy), .drop_incmpt_pkt(drop), .grant_id(gid), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_mvld"}, 32'(m_vld), 0);
        chk({tag, "_srdy"}, 32'(s_rdy), 0);
        chk({tag, "_mdat"}, 32'(m_dat), 0);
    endtask

    task automatic chk_beat(input string tag, input int src, input logic [7:0] dat,
                            input logic last, input logic [7:0] mty);
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        exp_rdy[src] = m_rdy;
        chk({tag, "_gid"},  32'(gid), 32'(src));
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_mvld"}, 32'(m_vld), 1);
        chk({tag, "_mdat"}, 32'(m_dat), 32'(dat));
        chk({tag, "_last"}, 32'(m_last), 32'(last));
        chk({tag, "_mty"},  32'(m_mty), 32'(mty));
        chk({tag, "_srdy"}, 32'(s_rdy), 32'(exp_rdy));
    endtask

    task automatic drive_all();
        for (int i = 0; i < N; i++) begin
            d[i] = 8'(i * 16 + c[i]);
            l[i] = (c[i] == 2);
            m[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        adv();
        aresetn = 1'b1;
    endtask

    initial begin
        v = '0; l = '0; m_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin d[i] = 8'h00; m[i] = 8'h00; c[i] = 0; end

        // Reset values
        #2 aresetn = 1'b0;
        #1;
        chk_idle("rst");
        chk("rst_gid", 32'(gid), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_last", 32'(m_last), 0);
        adv(); adv();
        aresetn = 1'b1;

        // Lone source 2, 13-beat packet
        v[2] = 1'b1; d[2] = 8'h01;
        #1 chk_idle("t1_arb");
        adv();
        for (int b = 1; b <= 13; b++) begin
            d[2] = 8'(b); l[2] = (b == 13); m[2] = (b == 13) ? 8'h01 : 8'h00;
            #1 chk_beat("t1_beat", 2, 8'(b), (b == 13), (b == 13) ? 8'h01 : 8'h00);
            adv();
        end
        v[2] = 1'b0; l[2] = 1'b0; m[2] = 8'h00;
        #1 chk_idle("t1_end");
        chk("t1_gid_hold", 32'(gid), 2);

        // All four sources with back-to-back 3-beat packets
        do_reset();
        v = '1;
        drive_all();
        for (int p = 0; p < 5; p++) begin
            #1 chk_idle("t2_gap");
            adv();
            for (int b = 0; b < 3; b++) begin
                #1 chk_beat("t2_beat", p % 4, 8'((p % 4) * 16 + b), (b == 2), 8'h00);
                adv();
                c[p % 4] = (c[p % 4] + 1) % 3;
                drive_all();
            end
        end

        // Source 1 with ready toggling 1,0,0,1
        v = 4'b0010;
        #1 chk_idle("t3_arb");
        adv();
        #1 chk_beat("t3_b0", 1, 8'h10, 1'b0, 8'h00);
        adv(); c[1] = 1; drive_all();
        m_rdy = 1'b0;
        #1 chk_beat("t3_stall1", 1, 8'h11, 1'b0, 8'h00);
        adv();
        #1 chk_beat("t3_stall2", 1, 8'h11, 1'b0, 8'h00);
        adv();
        m_rdy = 1'b1;
        #1 chk_beat("t3_b1", 1, 8'h11, 1'b0, 8'h00);
        adv(); c[1] = 2; drive_all();
        #1 chk_beat("t3_b2", 1, 8'h12, 1'b1, 8'h00);
        adv();
        v = '0; l = '0;
        #1 chk_idle("t3_end");

        // Source 0 starves mid-packet while source 1 waits
        do_reset();
        v = 4'b0011; d[1] = 8'h51; l[1] = 1'b1;
        #1 chk_idle("t4_arb");
        adv();
        for (int b = 1; b <= 5; b++) begin
            d[0] = 8'(8'h40 + b);
            #1 chk_beat("t4_beat", 0, 8'(8'h40 + b), 1'b0, 8'h00);
            adv();
        end
        v[0] = 1'b0;
`ifdef AXIS_ARB_WDOG_EN
        for (int k = 1; k <= 64; k++) begin
            #1 chk("t4_starve_drop", 32'(drop), 0);
            chk("t4_starve_busy", 32'(busy), 1);
            adv();
        end
        #1 chk("t4_pulse", 32'(drop), 1);
        chk_idle("t4_pulse");
        adv();
        #1 chk("t4_pulse_once", 32'(drop), 0);
`else
        for (int k = 1; k <= 70; k++) begin
            #1 chk("t4_wait_drop", 32'(drop), 0);
            chk("t4_wait_busy", 32'(busy), 1);
            chk("t4_wait_gid", 32'(gid), 0);
            adv();
        end
        v[0] = 1'b1; d[0] = 8'h46; l[0] = 1'b1;
        #1 chk_beat("t4_tail", 0, 8'h46, 1'b1, 8'h00);
        adv();
        v[0] = 1'b0; l[0] = 1'b0;
        #1 chk_idle("t4_arb2");
        adv();
`endif
        chk_beat("t4_src1", 1, 8'h51, 1'b1, 8'h00);
        adv();
        v = '0; l = '0;
        #1 chk_idle("t4_end");

        // Reset pulled mid-packet from source 3
        v[3] = 1'b1;
        #1 chk_idle("t5_arb");
        adv();
        for (int b = 1; b <= 6; b++) begin
            d[3] = 8'(8'h30 + b);
            #1 chk_beat("t5_beat", 3, 8'(8'h30 + b), 1'b0, 8'h00);
            if (b < 6) adv();
        end
        aresetn = 1'b0;
        #1 chk_idle("t5_rst");
        chk("t5_rst_gid", 32'(gid), 0);
        chk("t5_rst_last", 32'(m_last), 0);
        adv();
        aresetn = 1'b1;

        // Single-beat packets from sources 0 and 2; source 0 must win first after reset
        v = 4'b0101; d[0] = 8'hA0; d[2] = 8'hA2; l = 4'b0101;
        for (int p = 0; p < 4; p++) begin
            #1 chk_idle("t6_gap");
            adv();
            #1 chk_beat("t6_pkt", (p % 2) * 2, (p % 2) ? 8'hA2 : 8'hA0, 1'b1, 8'h00);
            adv();
        end
        v = '0; l = '0;
        #1 chk_idle("t6_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
